// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyphs, FSM states and slot width for the 7-segment scanner
package seg_pkg;

    localparam int SLOT_W = 2;

    // Segment order {a,b,c,d,e,f,g,dp}; dp is always 0 in the glyphs.
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_A     = 8'hEE;
    localparam logic [7:0] SEG_B     = 8'h3E;
    localparam logic [7:0] SEG_C     = 8'h9C;
    localparam logic [7:0] SEG_D     = 8'h7A;
    localparam logic [7:0] SEG_E     = 8'h9E;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        S_INIT,
        S_SCAN
    } state_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// rtl/seg7_hex_dec.sv - combinational hex nibble to a..g segment decoder
module seg7_hex_dec (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    import seg_pkg::*;

    always_comb begin
        seg = SEG_BLANK[7:1];
        case (hex)
            4'h0: seg = SEG_0[7:1];
            4'h1: seg = SEG_1[7:1];
            4'h2: seg = SEG_2[7:1];
            4'h3: seg = SEG_3[7:1];
            4'h4: seg = SEG_4[7:1];
            4'h5: seg = SEG_5[7:1];
            4'h6: seg = SEG_6[7:1];
            4'h7: seg = SEG_7[7:1];
            4'h8: seg = SEG_8[7:1];
            4'h9: seg = SEG_9[7:1];
            4'hA: seg = SEG_A[7:1];
            4'hB: seg = SEG_B[7:1];
            4'hC: seg = SEG_C[7:1];
            4'hD: seg = SEG_D[7:1];
            4'hE: seg = SEG_E[7:1];
            4'hF: seg = SEG_F[7:1];
            default: seg = SEG_BLANK[7:1];
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - dual-bank 4-digit 7-segment scanner with frame-synchronous shadow load
module seg_scan_ctrl #(
    parameter int DWELL_CYCLES = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_left,
    input  logic [15:0] digits_right,
    input  logic [7:0]  blank,
    input  logic [7:0]  dp,
    input  logic [7:0]  blink,
    output logic [7:0]  a_to_g_left,
    output logic [7:0]  a_to_g_right,
    output logic [3:0]  leftseg,
    output logic [3:0]  rightseg,
    output logic        frame_start
);
    import seg_pkg::*;

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    state_t              state_q, state_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [BW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                blink_phase_q, blink_phase_d;

    logic [15:0]         sh_left_q, sh_left_d;
    logic [15:0]         sh_right_q, sh_right_d;
    logic [7:0]          sh_blank_q, sh_blank_d;
    logic [7:0]          sh_dp_q, sh_dp_d;
    logic [7:0]          sh_blink_q, sh_blink_d;

    logic [7:0]          seg_left_q, seg_left_d;
    logic [7:0]          seg_right_q, seg_right_d;
    logic [3:0]          an_left_q, an_left_d;
    logic [3:0]          an_right_q, an_right_d;
    logic                frame_start_q, frame_start_d;

    logic                load;
    logic [3:0]          nib_left, nib_right;
    logic [6:0]          glyph_left, glyph_right;
    logic                dark_left, dark_right;

    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        slot_d        = slot_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        sh_left_d     = sh_left_q;
        sh_right_d    = sh_right_q;
        sh_blank_d    = sh_blank_q;
        sh_dp_d       = sh_dp_q;
        sh_blink_d    = sh_blink_q;
        load          = 1'b0;

        case (state_q)
            S_INIT: begin
                state_d = S_SCAN;
                load    = 1'b1;
            end
            S_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    slot_d  = slot_q + 1'b1;
                    if (slot_q == {SLOT_W{1'b1}}) begin
                        load = 1'b1;
                        // The first frame after reset is not counted, so it starts the blink period.
                        if (frame_cnt_q == BLINK_LAST) begin
                            frame_cnt_d   = '0;
                            blink_phase_d = ~blink_phase_q;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase

        if (load) begin
            sh_left_d  = digits_left;
            sh_right_d = digits_right;
            sh_blank_d = blank;
            sh_dp_d    = dp;
            sh_blink_d = blink;
            slot_d     = '0;
            dwell_d    = '0;
        end
    end

    // Outputs are built from the next-state values so they move on the same edge as the slot.
    assign nib_left  = sh_left_d[{slot_d, 2'b00} +: 4];
    assign nib_right = sh_right_d[{slot_d, 2'b00} +: 4];

    seg7_hex_dec u_dec_left (
        .hex (nib_left),
        .seg (glyph_left)
    );

    seg7_hex_dec u_dec_right (
        .hex (nib_right),
        .seg (glyph_right)
    );

    always_comb begin
        dark_left  = sh_blank_d[{1'b1, slot_d}] | (sh_blink_d[{1'b1, slot_d}] & ~blink_phase_d);
        dark_right = sh_blank_d[{1'b0, slot_d}] | (sh_blink_d[{1'b0, slot_d}] & ~blink_phase_d);

        an_left_d   = dark_left  ? 4'b0000 : (4'b0001 << slot_d);
        an_right_d  = dark_right ? 4'b0000 : (4'b0001 << slot_d);
        seg_left_d  = dark_left  ? SEG_BLANK : {glyph_left,  sh_dp_d[{1'b1, slot_d}]};
        seg_right_d = dark_right ? SEG_BLANK : {glyph_right, sh_dp_d[{1'b0, slot_d}]};
        frame_start_d = load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            dwell_q       <= '0;
            slot_q        <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            sh_left_q     <= '0;
            sh_right_q    <= '0;
            sh_blank_q    <= '1;
            sh_dp_q       <= '0;
            sh_blink_q    <= '0;
            seg_left_q    <= '0;
            seg_right_q   <= '0;
            an_left_q     <= '0;
            an_right_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            slot_q        <= slot_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_left_q     <= sh_left_d;
            sh_right_q    <= sh_right_d;
            sh_blank_q    <= sh_blank_d;
            sh_dp_q       <= sh_dp_d;
            sh_blink_q    <= sh_blink_d;
            seg_left_q    <= seg_left_d;
            seg_right_q   <= seg_right_d;
            an_left_q     <= an_left_d;
            an_right_q    <= an_right_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign a_to_g_left  = seg_left_q;
    assign a_to_g_right = seg_right_q;
    assign leftseg      = an_left_q;
    assign rightseg     = an_right_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl with DWELL_CYCLES=4, BLINK_FRAMES=2
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits_left, digits_right;
    logic [7:0]  blank, dp, blink;
    logic [7:0]  a_to_g_left, a_to_g_right;
    logic [3:0]  leftseg, rightseg;
    logic        frame_start;

    typedef struct packed {
        logic       fs;
        logic [3:0] ls;
        logic [7:0] al;
        logic [3:0] rs;
        logic [7:0] ar;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp, mon_got;
    int   checks = 0;
    int   failures = 0;
    int   popped = 0;
    int   cur;

    seg_scan_ctrl #(.DWELL_CYCLES(4), .BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .digits_left  (digits_left),
        .digits_right (digits_right),
        .blank        (blank),
        .dp           (dp),
        .blink        (blink),
        .a_to_g_left  (a_to_g_left),
        .a_to_g_right (a_to_g_right),
        .leftseg      (leftseg),
        .rightseg     (rightseg),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph_of(input logic [3:0] h);
        case (h)
            4'h0: return 8'hFC; 4'h1: return 8'h60; 4'h2: return 8'hDA; 4'h3: return 8'hF2;
            4'h4: return 8'h66; 4'h5: return 8'hB6; 4'h6: return 8'hBE; 4'h7: return 8'hE0;
            4'h8: return 8'hFE; 4'h9: return 8'hF6; 4'hA: return 8'hEE; 4'hB: return 8'h3E;
            4'hC: return 8'h9C; 4'hD: return 8'h7A; 4'hE: return 8'h9E; default: return 8'h8E;
        endcase
    endfunction

    function automatic exp_t frame_entry(input logic [15:0] dl, input logic [15:0] dr,
                                         input logic [7:0] bl, input logic [7:0] dpv,
                                         input logic [7:0] bk, input logic ph, input int j);
        exp_t e;
        int   k;
        logic dk;
        k    = j / 4;
        e.fs = (j == 0);
        dk   = bl[4+k] | (bk[4+k] & ~ph);
        e.ls = dk ? 4'b0000 : 4'(1 << k);
        e.al = dk ? 8'h00 : (glyph_of(dl[4*k +: 4]) | {7'b0, dpv[4+k]});
        dk   = bl[k] | (bk[k] & ~ph);
        e.rs = dk ? 4'b0000 : 4'(1 << k);
        e.ar = dk ? 8'h00 : (glyph_of(dr[4*k +: 4]) | {7'b0, dpv[k]});
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] dl, input logic [15:0] dr,
                              input logic [7:0] bl, input logic [7:0] dpv,
                              input logic [7:0] bk, input logic ph, input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(frame_entry(dl, dr, bl, dpv, bk, ph, j));
    endtask

    task automatic push_zero();
        exp_t z;
        z = '0;
        exp_q.push_back(z);
    endtask

    task automatic goto_cycle(input int c);
        repeat (c - cur) @(posedge clk);
        #1;
        cur = c;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({frame_start, leftseg, a_to_g_left, rightseg, a_to_g_right} !== '0) begin
            failures++;
            $display("FAIL %s: got fs=%b ls=%b al=%h rs=%b ar=%h, required all zero",
                     name, frame_start, leftseg, a_to_g_left, rightseg, a_to_g_right);
        end
    endtask

    // Monitor: one scoreboard entry per displayed cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {frame_start, leftseg, a_to_g_left, rightseg, a_to_g_right};
            checks++;
            if (mon_got !== mon_exp) begin
                failures++;
                $display("FAIL scan_entry%0d: got fs=%b ls=%b al=%h rs=%b ar=%h, required fs=%b ls=%b al=%h rs=%b ar=%h",
                         popped, mon_got.fs, mon_got.ls, mon_got.al, mon_got.rs, mon_got.ar,
                         mon_exp.fs, mon_exp.ls, mon_exp.al, mon_exp.rs, mon_exp.ar);
            end
            popped++;
        end
    end

    initial begin
        digits_left  = 16'h3210;
        digits_right = 16'h00F5;
        blank        = 8'h00;
        dp           = 8'h00;
        blink        = 8'h00;
        #1 rst = 1'b1;
        #2 check_zero("reset_state");

        @(posedge clk);
        #1;
        push_zero();
        push_frame(16'h3210, 16'h00F5, 8'h00, 8'h00, 8'h00, 1'b1, 16);
        push_frame(16'h3210, 16'h00F5, 8'h00, 8'h00, 8'h00, 1'b1, 16);
        push_frame(16'h5555, 16'h00F5, 8'h00, 8'h00, 8'h00, 1'b0, 16);
        push_frame(16'h5555, 16'h00F5, 8'b0100_0001, 8'b0001_0000, 8'h00, 1'b1, 9);
        rst = 1'b0;
        cur = -1;

        goto_cycle(16 + 6);
        digits_left = 16'h5555;
        goto_cycle(32 + 3);
        blank = 8'b0100_0001;
        dp    = 8'b0001_0000;

        // Frame 3, slot 2: asynchronous reset between clock edges.
        goto_cycle(48 + 9);
        #2 rst = 1'b1;
        #1 check_zero("async_reset_mid_frame");

        repeat (3) @(posedge clk);
        #1;
        blank        = 8'h00;
        dp           = 8'h00;
        blink        = 8'b0001_0000;
        digits_left  = 16'h3218;
        @(posedge clk);
        #1;
        check_zero("held_reset");
        push_zero();
        push_frame(16'h3218, 16'h00F5, 8'h00, 8'h00, 8'b0001_0000, 1'b1, 16);
        push_frame(16'h3218, 16'h00F5, 8'h00, 8'h00, 8'b0001_0000, 1'b1, 16);
        push_frame(16'h3218, 16'h00F5, 8'h00, 8'h00, 8'b0001_0000, 1'b0, 16);
        push_frame(16'h3218, 16'h00F5, 8'h00, 8'h00, 8'b0001_0000, 1'b0, 16);
        push_frame(16'h3218, 16'h00F5, 8'h00, 8'h00, 8'b0001_0000, 1'b1, 16);
        push_frame(16'h3218, 16'h00F5, 8'h00, 8'h00, 8'b0001_0000, 1'b1, 16);
        rst = 1'b0;

        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d entries pending, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's two 4-digit 7-segment banks (left and right), which have separate segment buses and active-high one-hot anode enables. Both banks are scanned in parallel: digit slot k of each bank is lit for DWELL_CYCLES clocks, then the next slot. Display content is snapshotted into shadow registers at each frame boundary, so no frame shows a mix of old and new values. Supports per-digit blanking, decimal point and blink. Sits between the voter/result logic and the board pins.

Parameters:
DWELL_CYCLES, 100000, clocks per digit slot (1 ms at 100 MHz); legal range >= 1
BLINK_FRAMES, 125, frames per blink half-period (~0.5 s at defaults); legal range >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
digits_left  in  16  hex nibbles for left bank; [4k+3:4k] = slot k
digits_right  in  16  hex nibbles for right bank; same mapping
blank  in  8  [7:4] left slots 3..0, [3:0] right slots 3..0; 1 = digit dark
dp  in  8  same mapping as blank; 1 = decimal point lit
blink  in  8  same mapping as blank; 1 = digit blinks
a_to_g_left  out  8  left segments {a,b,c,d,e,f,g,dp}, active-high
a_to_g_right  out  8  right segments, same encoding
leftseg  out  4  left anode enable, one-hot, bit k = slot k
rightseg  out  4  right anode enable
frame_start  out  1  one-cycle pulse on the first cycle of every frame

Behaviour:
- Reset (async, immediate): all outputs 0; dwell counter 0; slot index 0; blink counter 0; blink_phase 1 (visible); shadow regs cleared, shadow blank all 1s; FSM -> S_INIT.
- FSM: S_INIT (one cycle after reset release) -> S_SCAN. On leaving S_INIT, and in S_SCAN when the dwell counter = DWELL_CYCLES-1 and slot = 3, load all inputs into the shadow regs, set slot 0, and clear the dwell counter.
- S_SCAN: the dwell counter increments every clock. At DWELL_CYCLES-1 it wraps to 0 and the slot advances 0->1->2->3->0.
- Outputs are registered and change on the same edge as the slot index. They always reflect the shadow regs, never the live inputs.
- frame_start is 1 exactly in the first cycle in which slot 0 is shown after a shadow load. A frame is 4*DWELL_CYCLES clocks.
- Per bank, slot k is dark if shadow blank = 1, or if shadow blink = 1 and blink_phase = 0. A dark slot drives anode 0000 and segments 8'h00. Otherwise the anode is 1<<k and the segments are decode(nibble) | shadow dp.
- Decode (bits 7:1; bit 0 = dp): 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E.
- Blink: the frame counter increments at each frame boundary. At BLINK_FRAMES it wraps to 0 and blink_phase toggles. The phase change takes effect from that new frame.
- Input changes during a frame are ignored until the next boundary. An input change on the boundary cycle itself is captured.
- DWELL_CYCLES = 1: the slot advances every clock, and the frame is 4 clocks.
- Reset asserted mid-frame: outputs go to 0 without a clock edge, and scanning restarts via S_INIT after release.

Decomposition:
- Package seg_pkg: 7-seg glyph constants (SEG_0..SEG_F), SEG_BLANK = 8'h00, the FSM state enum {S_INIT, S_SCAN}, and the slot index width (2).
- Sub-module seg7_hex_dec: combinational 4-bit -> 7-bit decoder. Instantiate once per bank.

Test Plan:
All scenarios use DWELL_CYCLES=4 and BLINK_FRAMES=2.
1. Assert rst; check outputs = 0. Release rst -> one S_INIT cycle, then frame_start = 1, leftseg = 0001, a_to_g_left = decode(digits_left[3:0]).
2. digits_left = 16'h3210, right = 16'h00F5, blank = 0, dp = 0 -> leftseg 0001/0010/0100/1000 for 4 clocks each, showing FC/60/DA/F2. Right bank shows B6, 8E, FC, FC. frame_start pulses every 16 clocks.
3. Change digits_left to 16'h5555 at clock 6 of a frame -> the current frame is unchanged. The new value first appears at the next frame_start (B6 on all left slots).
4. blank = 8'b0100_0001, dp = 8'b0001_0000 -> left slot 2 and right slot 0 drive anode 0000 with segments 00. Left slot 0 segments have bit0 = 1.
5. blink = 8'b0001_0000, digits_left[3:0] = 8 -> left slot 0 shows FE in frames 0-1, is dark in frames 2-3, shows FE again in frames 4-5.
6. Assert rst asynchronously while slot = 2 -> all outputs 0 in the same timestep with no clock edge. After release, scanning restarts at slot 0 with a frame_start pulse.
